// File: rtl/sensor_monitor_pkg.sv
// ============================================================================
// sensor_monitor_pkg : shared types and helpers for the sensor monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

package sensor_monitor_pkg;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        PENDING = 2'd1,
        FAULT   = 2'd2
    } chan_state_t;

    // Raw error: sensor 0 alone, or sensor 1 corroborated by sensor 2 or 3.
    function automatic logic raw_err(input logic [3:0] s);
        return s[0] | (s[1] & (s[2] | s[3]));
    endfunction

    function automatic int persist_cnt_w(input int persist);
        return ($clog2(persist + 1) < 1) ? 1 : $clog2(persist + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_channel.sv
// ============================================================================
// sensor_channel : one 4-sensor channel with persistence filter and sticky fault
// Revision: 1.0
// ============================================================================
`default_nettype none

module sensor_channel
    import sensor_monitor_pkg::*;
#(
    parameter int PERSIST = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sens,
    input  logic       clear,
    output logic       raw_error,
    output logic       fault,
    output logic       enter
);

    localparam int CW = persist_cnt_w(PERSIST);
    localparam logic [CW-1:0] C_LAST = CW'(PERSIST - 1);

    chan_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_fault;
    logic          w_raw;

    assign w_raw     = raw_err(sens);
    assign raw_error = w_raw;
    assign fault     = r_fault;

    // Entry decision is made in the same cycle so the top can count it on this edge.
    assign enter = w_raw &&
                   (((r_state == OK) && (PERSIST == 1)) ||
                    ((r_state == PENDING) && (r_cnt == C_LAST)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OK;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                OK: begin
                    if (w_raw && (PERSIST == 1)) begin
                        r_state <= FAULT;
                        r_cnt   <= '0;
                        r_fault <= 1'b1;
                    end else if (w_raw) begin
                        r_state <= PENDING;
                        r_cnt   <= CW'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                PENDING: begin
                    if (!w_raw) begin
                        r_state <= OK;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= FAULT;
                        r_cnt   <= '0;
                        r_fault <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                FAULT: begin
                    if (clear && !w_raw) begin
                        r_state <= OK;
                        r_cnt   <= '0;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state <= OK;
                    r_cnt   <= '0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/sensor_monitor.sv
// ============================================================================
// sensor_monitor : multi-channel sensor fault monitor with saturating event count
// Revision: 1.0
// ============================================================================
`default_nettype none

module sensor_monitor
    import sensor_monitor_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PERSIST = 3,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*NUM_CH-1:0] sensors,
    input  logic [NUM_CH-1:0]   clear,
    input  logic                clear_count,
    output logic [NUM_CH-1:0]   raw_error,
    output logic [NUM_CH-1:0]   fault,
    output logic                any_fault,
    output logic [CNT_W-1:0]    fault_count
);

    localparam int CH_W = $clog2(NUM_CH + 1);
    localparam int SW   = ((CNT_W > CH_W) ? CNT_W : CH_W) + 1;
    localparam logic [SW-1:0] C_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [NUM_CH-1:0] w_enter;
    logic [SW-1:0]     w_enter_sum;
    logic [SW-1:0]     w_total;
    logic [CNT_W-1:0]  r_count;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            sensor_channel #(
                .PERSIST (PERSIST)
            ) u_channel (
                .clk       (clk),
                .rst       (rst),
                .sens      (sensors[4*g +: 4]),
                .clear     (clear[g]),
                .raw_error (raw_error[g]),
                .fault     (fault[g]),
                .enter     (w_enter[g])
            );
        end
    endgenerate

    always_comb begin
        w_enter_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_enter_sum = w_enter_sum + SW'(w_enter[i]);
        end
    end

    // A clear_count still keeps this edge's entries so no event is lost.
    assign w_total = clear_count ? w_enter_sum
                                 : ({{(SW-CNT_W){1'b0}}, r_count} + w_enter_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_total > C_MAX) begin
            r_count <= {CNT_W{1'b1}};
        end else begin
            r_count <= w_total[CNT_W-1:0];
        end
    end

    assign fault_count = r_count;
    assign any_fault   = |fault;

endmodule

`default_nettype wire

// File: tb/tb_sensor_monitor.sv
// ============================================================================
// tb_sensor_monitor : self-checking bench for sensor_monitor (2 ch, PERSIST 3, 4-bit count)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sensor_monitor;

    localparam int NUM_CH  = 2;
    localparam int PERSIST = 3;
    localparam int CNT_W   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sensors;
    logic [1:0] clear;
    logic       clear_count;
    logic [1:0] raw_error;
    logic [1:0] fault;
    logic       any_fault;
    logic [3:0] fault_count;

    sensor_monitor #(
        .NUM_CH  (NUM_CH),
        .PERSIST (PERSIST),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensors     (sensors),
        .clear       (clear),
        .clear_count (clear_count),
        .raw_error   (raw_error),
        .fault       (fault),
        .any_fault   (any_fault),
        .fault_count (fault_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] sens;
        logic [1:0] clr;
        logic       cc;
        logic [1:0] exp_fault;
        logic [3:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [1:0] f;
        logic       any;
        logic [3:0] cnt;
        string      nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_count;

    function automatic logic ref_raw(input logic [3:0] s);
        return s[0] | (s[1] & (s[2] | s[3]));
    endfunction

    function automatic vec_t mk(input logic r, input logic [7:0] s, input logic [1:0] c,
                                input logic cc, input logic [1:0] ef, input logic [3:0] ec);
        vec_t v;
        v.rst = r; v.sens = s; v.clr = c; v.cc = cc; v.exp_fault = ef; v.exp_cnt = ec;
        return v;
    endfunction

    // Drive one cycle of stimulus, check raw_error combinationally, then check state after the edge.
    task automatic step(input logic r, input logic [7:0] s, input logic [1:0] c, input logic cc,
                        input logic [1:0] ef, input logic [3:0] ec, input string nm);
        exp_t e;
        logic [1:0] er;
        rst = r; sensors = s; clear = c; clear_count = cc;
        er = {ref_raw(s[7:4]), ref_raw(s[3:0])};
        e.f = ef; e.any = |ef; e.cnt = ec; e.nm = nm;
        sb.push_back(e);
        #1;
        checks++;
        if (raw_error !== er) begin
            errors++;
            $display("FAIL %s raw_error: got %b expected %b", nm, raw_error, er);
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            checks++;
            if (fault !== e.f || any_fault !== e.any || fault_count !== e.cnt) begin
                errors++;
                $display("FAIL %s outputs: got fault=%b any=%b count=%0d expected fault=%b any=%b count=%0d",
                         e.nm, fault, any_fault, fault_count, e.f, e.any, e.cnt);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sensors = '0; clear = '0; clear_count = 1'b0;
        @(negedge clk);

        tbl.push_back(mk(1, 8'h00, 2'b00, 0, 2'b00, 4'd0));
        tbl.push_back(mk(1, 8'h00, 2'b00, 0, 2'b00, 4'd0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 8'h00, 2'b00, 0, 2'b00, 4'd0));
        // Channel 0 persists three cycles
        tbl.push_back(mk(0, 8'h01, 2'b00, 0, 2'b00, 4'd0));
        tbl.push_back(mk(0, 8'h01, 2'b00, 0, 2'b00, 4'd0));
        tbl.push_back(mk(0, 8'h01, 2'b00, 0, 2'b01, 4'd1));
        // Channel 1 glitch of two cycles
        tbl.push_back(mk(0, 8'h61, 2'b00, 0, 2'b01, 4'd1));
        tbl.push_back(mk(0, 8'h61, 2'b00, 0, 2'b01, 4'd1));
        tbl.push_back(mk(0, 8'h21, 2'b00, 0, 2'b01, 4'd1));
        tbl.push_back(mk(0, 8'h21, 2'b00, 0, 2'b01, 4'd1));
        // Clear refused while raw high, accepted once raw drops
        tbl.push_back(mk(0, 8'h01, 2'b01, 0, 2'b01, 4'd1));
        tbl.push_back(mk(0, 8'h00, 2'b00, 0, 2'b01, 4'd1));
        tbl.push_back(mk(0, 8'h00, 2'b01, 0, 2'b00, 4'd1));
        tbl.push_back(mk(0, 8'h00, 2'b00, 0, 2'b00, 4'd1));
        // Simultaneous entry on both channels
        tbl.push_back(mk(0, 8'h61, 2'b00, 0, 2'b00, 4'd1));
        tbl.push_back(mk(0, 8'h61, 2'b00, 0, 2'b00, 4'd1));
        tbl.push_back(mk(0, 8'h61, 2'b00, 0, 2'b11, 4'd3));
        tbl.push_back(mk(0, 8'h61, 2'b11, 0, 2'b11, 4'd3));
        tbl.push_back(mk(0, 8'h00, 2'b11, 0, 2'b00, 4'd3));
        tbl.push_back(mk(0, 8'h00, 2'b00, 0, 2'b00, 4'd3));
        // Clear held during PENDING does not restart the window
        tbl.push_back(mk(0, 8'h10, 2'b10, 0, 2'b00, 4'd3));
        tbl.push_back(mk(0, 8'h10, 2'b10, 0, 2'b00, 4'd3));
        tbl.push_back(mk(0, 8'h10, 2'b10, 0, 2'b10, 4'd4));
        tbl.push_back(mk(0, 8'h00, 2'b10, 0, 2'b00, 4'd4));
        tbl.push_back(mk(0, 8'h00, 2'b00, 0, 2'b00, 4'd4));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].sens, tbl[i].clr, tbl[i].cc,
                 tbl[i].exp_fault, tbl[i].exp_cnt, $sformatf("vec%0d", i));
        end

        // Saturation: double entries until the count pins at 15
        exp_count = 4;
        for (int r = 0; r < 7; r++) begin
            step(0, 8'h61, 2'b00, 0, 2'b00, 4'(exp_count), $sformatf("sat%0d_a", r));
            step(0, 8'h61, 2'b00, 0, 2'b00, 4'(exp_count), $sformatf("sat%0d_b", r));
            exp_count = (exp_count + 2 > 15) ? 15 : exp_count + 2;
            step(0, 8'h61, 2'b00, 0, 2'b11, 4'(exp_count), $sformatf("sat%0d_c", r));
            step(0, 8'h00, 2'b11, 0, 2'b00, 4'(exp_count), $sformatf("sat%0d_clr", r));
        end
        step(0, 8'h01, 2'b00, 0, 2'b00, 4'd15, "sat_single_a");
        step(0, 8'h01, 2'b00, 0, 2'b00, 4'd15, "sat_single_b");
        step(0, 8'h01, 2'b00, 0, 2'b01, 4'd15, "sat_single_c");
        step(0, 8'h00, 2'b01, 0, 2'b00, 4'd15, "sat_single_clr");

        // clear_count coincident with a new entry keeps that entry
        step(0, 8'h01, 2'b00, 0, 2'b00, 4'd15, "cc_a");
        step(0, 8'h01, 2'b00, 0, 2'b00, 4'd15, "cc_b");
        step(0, 8'h01, 2'b00, 1, 2'b01, 4'd1,  "cc_entry");
        step(0, 8'h00, 2'b01, 0, 2'b00, 4'd1,  "cc_clr");
        step(0, 8'h00, 2'b00, 1, 2'b00, 4'd0,  "cc_only");

        // Reset mid-PENDING discards the partial window
        step(0, 8'h01, 2'b00, 0, 2'b00, 4'd0, "rp_a");
        step(0, 8'h01, 2'b00, 0, 2'b00, 4'd0, "rp_b");
        step(1, 8'h01, 2'b00, 0, 2'b00, 4'd0, "rp_rst");
        step(0, 8'h01, 2'b00, 0, 2'b00, 4'd0, "rp_1");
        step(0, 8'h01, 2'b00, 0, 2'b00, 4'd0, "rp_2");
        step(0, 8'h01, 2'b00, 0, 2'b01, 4'd1, "rp_3");

        // Reset overrides clear_count and a pending entry edge
        step(0, 8'h00, 2'b01, 0, 2'b00, 4'd1, "rs_clr");
        step(0, 8'h10, 2'b00, 0, 2'b00, 4'd1, "rs_a");
        step(0, 8'h10, 2'b00, 0, 2'b00, 4'd1, "rs_b");
        step(1, 8'h10, 2'b00, 1, 2'b00, 4'd0, "rs_rst");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sensor_monitor.md
Name: sensor_monitor

Overview:
- Multi-channel successor to the single 4-sensor error detector.
- Each channel has 4 sensors and uses the same raw-error equation.
- A raw error must persist for PERSIST consecutive cycles before the channel latches a sticky fault, which filters out glitches.
- Faults stay latched until software clears them. Fault events are counted per block, and the block feeds the system status/interrupt logic.

Parameters:
- NUM_CH, 4, number of 4-sensor channels (1..16).
- PERSIST, 3, consecutive cycles of raw error required to declare a fault (1..255).
- CNT_W, 8, width of the saturating fault-event counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- sensors  input  4*NUM_CH  channel i occupies bits [4i+3:4i]; already synchronised upstream.
- clear  input  NUM_CH  per-channel fault clear request, level-sampled.
- clear_count  input  1  zeroes fault_count.
- raw_error  output  NUM_CH  combinational per-channel raw error.
- fault  output  NUM_CH  registered sticky fault per channel.
- any_fault  output  1  OR of fault, registered-equivalent (derived from fault only).
- fault_count  output  CNT_W  saturating count of fault entries.

Behaviour:
- Raw error per channel: raw_error[i] = s[4i] | (s[4i+1] & (s[4i+2] | s[4i+3])).
- Reset (rst high at an edge):
  - all channels go to OK with persistence count 0.
  - fault = 0, any_fault = 0, fault_count = 0.
  - raw_error stays combinational from sensors.
- Per-channel FSM, states OK, PENDING, FAULT; persistence counter width clog2(PERSIST+1).
  - OK:
    - raw high and PERSIST==1 -> FAULT.
    - raw high otherwise -> PENDING, cnt=1.
    - raw low -> stay, cnt=0.
  - PENDING:
    - raw low -> OK, cnt=0.
    - raw high and cnt==PERSIST-1 -> FAULT.
    - raw high otherwise -> cnt+1.
  - FAULT:
    - clear[i] high and raw low -> OK, cnt=0.
    - clear[i] high and raw high -> stay FAULT; no new event counted.
    - clear[i] low -> stay FAULT regardless of raw.
- Latency: raw high sampled at edges 1..PERSIST -> fault[i] rises right after edge PERSIST. fault equals (state==FAULT).
- Deassertion: fault[i] falls immediately after the edge that samples a valid clear.
- Clear in OK or PENDING: no effect; the PENDING count is not reset by clear.
- Fault event: a channel transitioning into FAULT in a cycle.
- fault_count update per edge:
  - fault_count <= sat(fault_count + number of channels entering FAULT that cycle).
  - Saturates at 2^CNT_W-1 and never wraps.
  - Simultaneous entries across channels all count in the same edge.
- clear_count:
  - clear_count high: fault_count <= number of channels entering FAULT that cycle, so events are never lost.
  - rst has priority over clear_count and over all FSM transitions.
- Reset mid-PENDING: count discarded; a new PERSIST-cycle window is required after reset.
- Width rules:
  - Event-sum adder width is max(CNT_W, clog2(NUM_CH+1)) + 1, then clamped.
  - No truncation before the saturation compare.

Decomposition:
- Package sensor_monitor_pkg holds:
  - the chan_state_t enum (OK, PENDING, FAULT), 2-bit encoded.
  - the function raw_err(logic [3:0]).
  - the localparam helper for the persistence-count width.
- Sub-module sensor_channel:
  - one instance per channel via generate.
  - ports: clk, rst, sens[3:0], clear, raw_error, fault, enter (1-cycle pulse on FAULT entry).
- The top level sums the enter pulses into fault_count and ORs fault into any_fault.

Test Plan (NUM_CH=2, PERSIST=3, CNT_W=4):
- Reset, then sensors=8'h00 for 5 cycles -> fault=2'b00, any_fault=0, fault_count=0.
- Channel 0 sensors=4'b0001 held 3 cycles -> raw_error[0]=1 immediately; fault[0]=1 after 3rd edge; fault_count=1.
- Glitch: channel 1 sensors=4'b0110 for 2 cycles, then 4'b0010 (raw low) -> fault[1] stays 0 and the count is unchanged.
- Both channels raw high 3 cycles together -> fault=2'b11 after edge 3; fault_count increments by 2 in one edge.
- Clear:
  - clear[0]=1 while ch0 raw still high -> fault[0] stays 1, count unchanged.
  - Drop ch0 raw, then clear[0]=1 -> fault[0]=0 next cycle.
- Saturation:
  - Repeat fault/clear cycles until the count reaches 15; a further event keeps 15.
  - clear_count=1 together with a new entry -> fault_count=1.
  - rst asserted mid-PENDING -> count restarts, and fault needs 3 fresh cycles.
